// File: rtl/seq_stim_tx_pkg.sv
// Shared constants for the serial stimulus transmitter: FSM encoding, LFSR taps
// and the hit-counter width.
package seq_stim_tx_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SEND = 2'd1;
    localparam state_t ST_GAP  = 2'd2;

    // Right-shifting Fibonacci form: taps 16,14,13,11 land on bits 0,2,3,5.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    localparam int                HIT_W   = 8;
    localparam logic [HIT_W-1:0]  HIT_MAX = '1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/seq_stim_tx_lfsr16.sv
// 16-bit Fibonacci LFSR; steps once per enabled clock and resets to SEED.
module seq_stim_tx_lfsr16
    import seq_stim_tx_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/seq_stim_tx.sv
// Serial stimulus transmitter: drives a detector's A input from a pattern word or
// an LFSR, one bit per HOLD cycles, and counts the cycles where the detector's Y is high.
module seq_stim_tx
    import seq_stim_tx_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int          HOLD  = 1,
    parameter int          GAP   = 2,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       LOAD_VALID,
    output logic                       LOAD_READY,
    input  logic [WIDTH-1:0]           LOAD_DATA,
    input  logic [$clog2(WIDTH+1)-1:0] LOAD_LEN,
    input  logic                       LOAD_MODE,
    input  logic                       ABORT,
    input  logic                       Y,
    output logic                       A,
    output logic                       A_VALID,
    output logic                       DONE,
    output logic [HIT_W-1:0]           HIT_CNT
);

    localparam int LEN_W  = $clog2(WIDTH + 1);
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(WIDTH);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    state_t            state;
    logic [WIDTH-1:0]  shreg;
    logic [WIDTH-1:0]  shreg_shift;
    logic              mode;
    logic [LEN_W-1:0]  bits_left;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic [LEN_W-1:0]  len_eff;
    logic              in_burst;
    logic              bit_end;
    logic              lfsr_en;
    logic [15:0]       lfsr;
    logic              lfsr_unused;

    assign shreg_shift = shreg >> 1;
    assign in_burst    = (state == ST_SEND) || (state == ST_GAP);
    assign bit_end     = (state == ST_SEND) && (hold_cnt == HOLD_LAST);
    // An aborted bit period never completes, so the sequence does not step on it.
    assign lfsr_en     = bit_end && mode && !ABORT;
    assign lfsr_unused = ^lfsr[15:2];

    // NOTE: every path of a combinational block assigns its outputs, otherwise a latch is inferred.
    always_comb begin
        if ((LOAD_LEN == '0) || (LOAD_LEN > LEN_MAX)) begin
            len_eff = LEN_MAX;
        end else begin
            len_eff = LOAD_LEN;
        end
    end

    seq_stim_tx_lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (CLK),
        .rst   (RST),
        .en    (lfsr_en),
        .state (lfsr)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            mode       <= 1'b0;
            bits_left  <= '0;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            A          <= 1'b0;
            A_VALID    <= 1'b0;
            DONE       <= 1'b0;
            LOAD_READY <= 1'b1;
            HIT_CNT    <= '0;
        end else begin
            DONE <= 1'b0;

            if (in_burst && Y && !ABORT && (HIT_CNT != HIT_MAX)) begin
                HIT_CNT <= HIT_CNT + HIT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (LOAD_VALID) begin
                        state      <= ST_SEND;
                        shreg      <= LOAD_DATA;
                        mode       <= LOAD_MODE;
                        bits_left  <= len_eff;
                        hold_cnt   <= '0;
                        A          <= LOAD_MODE ? lfsr[0] : LOAD_DATA[0];
                        A_VALID    <= 1'b1;
                        LOAD_READY <= 1'b0;
                        HIT_CNT    <= '0;
                    end
                end

                ST_SEND: begin
                    if (ABORT) begin
                        state      <= ST_IDLE;
                        A          <= 1'b0;
                        A_VALID    <= 1'b0;
                        LOAD_READY <= 1'b1;
                    end else if (bit_end) begin
                        hold_cnt <= '0;
                        shreg    <= shreg_shift;
                        if (bits_left == LEN_W'(1)) begin
                            A       <= 1'b0;
                            A_VALID <= 1'b0;
                            if (GAP == 0) begin
                                state      <= ST_IDLE;
                                LOAD_READY <= 1'b1;
                                DONE       <= 1'b1;
                            end else begin
                                state   <= ST_GAP;
                                gap_cnt <= GAP_LAST;
                            end
                        end else begin
                            bits_left <= bits_left - LEN_W'(1);
                            // The LFSR steps on this same edge, so its next bit 0 is today's bit 1.
                            A         <= mode ? lfsr[1] : shreg_shift[0];
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end

                ST_GAP: begin
                    if (ABORT) begin
                        state      <= ST_IDLE;
                        LOAD_READY <= 1'b1;
                    end else if (gap_cnt == '0) begin
                        state      <= ST_IDLE;
                        LOAD_READY <= 1'b1;
                        DONE       <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    A          <= 1'b0;
                    A_VALID    <= 1'b0;
                    LOAD_READY <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_stim_tx.sv
// Bench for seq_stim_tx: three instances (HOLD/GAP = 1/2, 3/0, 40/2) share one stimulus
// stream and are compared every cycle against a per-instance timeline model.
module tb_seq_stim_tx;

    localparam int          WIDTH = 8;
    localparam int          NI    = 3;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic       clk        = 1'b0;
    logic       rst        = 1'b1;
    logic       load_valid = 1'b0;
    logic [7:0] load_data  = '0;
    logic [3:0] load_len   = '0;
    logic       load_mode  = 1'b0;
    logic       abort      = 1'b0;
    logic       y          = 1'b0;

    logic [NI-1:0] rdy_w, a_w, av_w, done_w;
    logic [7:0]    hit_w [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seq_stim_tx #(.WIDTH(8), .HOLD(1), .GAP(2), .SEED(SEED)) dut0 (
        .CLK(clk), .RST(rst), .LOAD_VALID(load_valid), .LOAD_READY(rdy_w[0]),
        .LOAD_DATA(load_data), .LOAD_LEN(load_len), .LOAD_MODE(load_mode), .ABORT(abort),
        .Y(y), .A(a_w[0]), .A_VALID(av_w[0]), .DONE(done_w[0]), .HIT_CNT(hit_w[0]));

    seq_stim_tx #(.WIDTH(8), .HOLD(3), .GAP(0), .SEED(SEED)) dut1 (
        .CLK(clk), .RST(rst), .LOAD_VALID(load_valid), .LOAD_READY(rdy_w[1]),
        .LOAD_DATA(load_data), .LOAD_LEN(load_len), .LOAD_MODE(load_mode), .ABORT(abort),
        .Y(y), .A(a_w[1]), .A_VALID(av_w[1]), .DONE(done_w[1]), .HIT_CNT(hit_w[1]));

    seq_stim_tx #(.WIDTH(8), .HOLD(40), .GAP(2), .SEED(SEED)) dut2 (
        .CLK(clk), .RST(rst), .LOAD_VALID(load_valid), .LOAD_READY(rdy_w[2]),
        .LOAD_DATA(load_data), .LOAD_LEN(load_len), .LOAD_MODE(load_mode), .ABORT(abort),
        .Y(y), .A(a_w[2]), .A_VALID(av_w[2]), .DONE(done_w[2]), .HIT_CNT(hit_w[2]));

    function automatic int hold_of(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 40;
        endcase
    endfunction

    function automatic int gap_of(input int i);
        return (i == 1) ? 0 : 2;
    endfunction

    function automatic logic [15:0] ref_adv(input logic [15:0] s, input int n);
        logic [15:0] r;
        r = s;
        for (int k = 0; k < n; k++) r = {r[0] ^ r[2] ^ r[3] ^ r[5], r[15:1]};
        return r;
    endfunction

    // Reference model: a burst is a timeline of nbits*HOLD stimulus cycles then GAP idle cycles.
    bit          m_busy  [NI];
    int          m_pos   [NI];
    int          m_nbits [NI];
    bit          m_mode  [NI];
    bit          m_done  [NI];
    int          m_hit   [NI];
    logic [15:0] m_lfsr  [NI];
    logic [15:0] m_start [NI];
    bit          m_bits  [NI][WIDTH];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            m_busy[i]  = 1'b0;
            m_pos[i]   = 0;
            m_nbits[i] = WIDTH;
            m_mode[i]  = 1'b0;
            m_done[i]  = 1'b0;
            m_hit[i]   = 0;
            m_lfsr[i]  = SEED;
            m_start[i] = SEED;
        end
    endtask

    task automatic model_edge();
        logic [15:0] s;
        int          steps;
        for (int i = 0; i < NI; i++) begin
            if (m_busy[i]) begin
                if (abort) begin
                    steps = m_pos[i] / hold_of(i);
                    if (steps > m_nbits[i]) steps = m_nbits[i];
                    if (m_mode[i]) m_lfsr[i] = ref_adv(m_start[i], steps);
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b0;
                end else begin
                    if (y && m_hit[i] < 255) m_hit[i]++;
                    m_pos[i]++;
                    if (m_pos[i] == m_nbits[i] * hold_of(i) + gap_of(i)) begin
                        m_busy[i] = 1'b0;
                        m_done[i] = 1'b1;
                        if (m_mode[i]) m_lfsr[i] = ref_adv(m_start[i], m_nbits[i]);
                    end
                end
            end else begin
                m_done[i] = 1'b0;
                if (load_valid) begin
                    m_nbits[i] = (load_len == 0 || load_len > WIDTH) ? WIDTH : int'(load_len);
                    m_mode[i]  = load_mode;
                    m_start[i] = m_lfsr[i];
                    for (int j = 0; j < m_nbits[i]; j++) begin
                        s = ref_adv(m_lfsr[i], j);
                        m_bits[i][j] = load_mode ? s[0] : load_data[j];
                    end
                    m_hit[i]  = 0;
                    m_pos[i]  = 0;
                    m_busy[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare_all();
        bit e_av;
        int e_a;
        for (int i = 0; i < NI; i++) begin
            e_av = m_busy[i] && (m_pos[i] < m_nbits[i] * hold_of(i));
            e_a  = e_av ? int'(m_bits[i][m_pos[i] / hold_of(i)]) : 0;
            check($sformatf("A[%0d]", i),          int'(a_w[i]),    e_a);
            check($sformatf("A_VALID[%0d]", i),    int'(av_w[i]),   int'(e_av));
            check($sformatf("DONE[%0d]", i),       int'(done_w[i]), int'(m_done[i]));
            check($sformatf("LOAD_READY[%0d]", i), int'(rdy_w[i]),  int'(!m_busy[i]));
            check($sformatf("HIT_CNT[%0d]", i),    int'(hit_w[i]),  m_hit[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        load_valid = 1'b0;
        abort      = 1'b0;
        y          = 1'b0;
        for (int t = 0; t < 400 && rdy_w != '1; t++) tick();
        check("drain_idle", int'(rdy_w), 7);
    endtask

    // Pulses one load into idle instances, runs until all have signalled DONE, and checks the
    // DONE cycle index (accept edge = edge 0). Y is high in cycles y_from..y_to.
    task automatic run_burst(input logic [7:0] d, input logic [3:0] len, input bit mode,
                             input int nb, input int y_from, input int y_to,
                             output logic [7:0] pat);
        int done_at [NI];
        load_data  = d;
        load_len   = len;
        load_mode  = mode;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        pat        = '0;
        for (int i = 0; i < NI; i++) done_at[i] = 0;
        for (int t = 1; t <= 400; t++) begin
            if (t <= WIDTH) pat[t-1] = a_w[0];
            for (int i = 0; i < NI; i++)
                if (done_w[i] && done_at[i] == 0) done_at[i] = t;
            if (done_at[0] != 0 && done_at[1] != 0 && done_at[2] != 0) break;
            y = (t >= y_from) && (t <= y_to);
            tick();
        end
        y = 1'b0;
        for (int i = 0; i < NI; i++)
            check($sformatf("done_cycle[%0d]", i), done_at[i], 1 + nb * hold_of(i) + gap_of(i));
    endtask

    logic [7:0]  pat;
    logic [7:0]  exp_pat;
    logic [15:0] s;

    initial begin
        model_reset();
        tick();
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_ready[%0d]", i), int'(rdy_w[i]), 1);
            check($sformatf("rst_hit[%0d]", i),   int'(hit_w[i]), 0);
        end
        rst = 1'b0;

        // Pattern burst LSB first, Y high for 5 SEND cycles.
        run_burst(8'b1011_0010, 4'd8, 1'b0, 8, 2, 6, pat);
        check("t1_pattern", int'(pat), 8'b1011_0010);
        for (int i = 0; i < NI; i++) check($sformatf("t1_hits[%0d]", i), int'(hit_w[i]), 5);

        // Two-bit burst; the new accept clears the hit count.
        run_burst(8'b0000_0010, 4'd2, 1'b0, 2, 0, 0, pat);
        check("t2_pattern", int'(pat[1:0]), 2);
        check("t2_hits_cleared", int'(hit_w[0]), 0);

        // Length corners: 0 and over-range both mean WIDTH.
        run_burst(8'($urandom), 4'd0, 1'b0, 8, 0, 0, pat);
        run_burst(8'($urandom), 4'd15, 1'b0, 8, 0, 0, pat);

        // Held LOAD_VALID: every DONE cycle doubles as the next accept.
        load_valid = 1'b1;
        for (int t = 0; t < 120; t++) begin
            load_data = 8'($urandom);
            load_len  = 4'($urandom_range(1, 8));
            load_mode = 1'($urandom);
            y         = 1'($urandom);
            tick();
        end
        drain();

        // LFSR mode from SEED; a second burst continues the sequence.
        reset_pulse();
        run_burst(8'h00, 4'd8, 1'b1, 8, 0, 0, pat);
        for (int j = 0; j < 8; j++) begin
            s = ref_adv(SEED, j);
            exp_pat[j] = s[0];
        end
        check("lfsr_burst1", int'(pat), int'(exp_pat));
        run_burst(8'h00, 4'd8, 1'b1, 8, 0, 0, pat);
        for (int j = 0; j < 8; j++) begin
            s = ref_adv(SEED, 8 + j);
            exp_pat[j] = s[0];
        end
        check("lfsr_burst2", int'(pat), int'(exp_pat));

        // Y held high for the whole burst: HOLD=40 saturates at 255.
        run_burst(8'($urandom), 4'd8, 1'b0, 8, 1, 400, pat);
        check("sat_hits[0]", int'(hit_w[0]), 10);
        check("sat_hits[1]", int'(hit_w[1]), 24);
        check("sat_hits[2]", int'(hit_w[2]), 255);

        // ABORT during the third SEND cycle.
        load_data  = 8'hFF;
        load_len   = 4'd8;
        load_mode  = 1'b0;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_av", int'(av_w), 0);
        check("abort_ready", int'(rdy_w), 7);
        check("abort_done", int'(done_w), 0);
        for (int t = 0; t < 5; t++) tick();

        // Asynchronous reset between edges while dut0 is in GAP.
        load_len   = 4'd1;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        check("arst_a",     int'(a_w),    0);
        check("arst_av",    int'(av_w),   0);
        check("arst_done",  int'(done_w), 0);
        check("arst_ready", int'(rdy_w),  7);
        for (int i = 0; i < NI; i++) check($sformatf("arst_hit[%0d]", i), int'(hit_w[i]), 0);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        run_burst(8'h00, 4'd8, 1'b1, 8, 0, 0, pat);
        for (int j = 0; j < 8; j++) begin
            s = ref_adv(SEED, j);
            exp_pat[j] = s[0];
        end
        check("lfsr_after_rst", int'(pat), int'(exp_pat));

        // Random traffic.
        for (int t = 0; t < 2500; t++) begin
            load_valid = 1'($urandom);
            load_data  = 8'($urandom);
            load_len   = 4'($urandom);
            load_mode  = 1'($urandom);
            abort      = ($urandom_range(0, 39) == 0);
            y          = 1'($urandom);
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
